axi4_ar_rr_arbiter: RTL and testbench
=====================================

// Module: axi4_ar_rr_arbiter
// PURPOSE
// - Shares one downstream AXI4 read port (AR + R channels) between NUM_M upstream read masters.
// - AR requests are granted round-robin and forwarded downstream with a master-index prefix on ARID.
// - R beats are routed back to the owning master by that prefix; total outstanding bursts are capped.
// - Sits between a multi-master read fabric and a single axi4_if slave-side read port.
// PARAMETERS
// NUM_M      4   number of upstream masters (>=2); SEL_W = $clog2(NUM_M)
// ADDR_W     32  address width
// DATA_W     64  data width
// ID_W       4   upstream ID width; downstream ID width is ID_W+SEL_W
// MAX_OUTST  8   max outstanding downstream read bursts (>=1); CNT_W = $clog2(MAX_OUTST+1)
// PORTS
// aclk        in   1               clock; all logic on posedge
// areset_n    in   1               asynchronous active-low reset
// s_arid      in   NUM_M*ID_W      per-master ARID, master i at slice [i*ID_W +: ID_W]
// s_araddr    in   NUM_M*ADDR_W    per-master ARADDR
// s_arlen     in   NUM_M*8         per-master ARLEN
// s_arsize    in   NUM_M*3         per-master ARSIZE
// s_arburst   in   NUM_M*2         per-master ARBURST
// s_arvalid   in   NUM_M           per-master ARVALID
// s_arready   out  NUM_M           per-master ARREADY
// s_rid       out  NUM_M*ID_W      per-master RID (prefix stripped)
// s_rdata     out  NUM_M*DATA_W    per-master RDATA (broadcast)
// s_rresp     out  NUM_M*2         per-master RRESP (broadcast)
// s_rlast     out  NUM_M           per-master RLAST
// s_rvalid    out  NUM_M           per-master RVALID
// s_rready    in   NUM_M           per-master RREADY
// m_arid      out  ID_W+SEL_W      {grant_idx, s_arid[grant]}
// m_araddr / m_arlen / m_arsize / m_arburst  out  ADDR_W / 8 / 3 / 2  granted request fields
// m_arvalid   out  1               downstream ARVALID
// m_arready   in   1               downstream ARREADY
// m_rid / m_rdata / m_rresp / m_rlast / m_rvalid  in  ID_W+SEL_W / DATA_W / 2 / 1 / 1  downstream R
// m_rready    out  1               downstream RREADY
// outst_cnt   out  CNT_W           current outstanding burst count
// err_decode  out  1               one-cycle pulse: R beat with prefix >= NUM_M
// BEHAVIOUR
// - Reset (async assert, sync-safe deassert): m_arvalid=0, s_arready=0, outst_cnt=0, err_decode=0, FSM=IDLE.
// - Reset: last_grant=NUM_M-1, so master 0 has priority first.
// - AR FSM, two states:
//   - IDLE: if outst_cnt<MAX_OUTST and any s_arvalid, pick the first valid index scanning from last_grant+1 (mod NUM_M).
//     Register the grant and all fields of that request. Go to ISSUE. s_arready stays 0 in IDLE.
//   - ISSUE: m_arvalid=1; m_ar* come from the registered copy and are stable until handshake.
//     m_arready=1 completes the handshake in that same cycle: s_arready[grant] pulses 1 (completes the upstream handshake),
//     last_grant<=grant, outst_cnt increments, FSM returns to IDLE.
// - Upstream requests are captured at grant; s_arready pulses only on the downstream handshake, so the upstream request is held until then.
// - Throughput: at most one AR per 2 cycles (one arbitration bubble). AR latency upstream->downstream is 1 cycle.
// - outst_cnt == MAX_OUTST: no new grant; an AR already in ISSUE is not reached in that state, because the count is checked at grant.
// - R path, combinational, zero latency:
//   - sel = m_rid[ID_W+SEL_W-1:ID_W]; s_rvalid[sel]=m_rvalid; m_rready=s_rready[sel].
//   - s_rid[sel] = m_rid[ID_W-1:0]; s_rlast[sel] = m_rlast.
//   - Other masters see rvalid=0.
// - sel >= NUM_M (non-power-of-2 NUM_M): m_rready=1 (beat sunk), no s_rvalid, err_decode=1 that cycle.
// - outst_cnt decrements on m_rvalid&m_rready&m_rlast, including sunk beats, and never below 0.
//   Simultaneous increment and decrement: count unchanged.
// - Reset mid-burst: all state cleared; downstream in-flight beats after reset are the environment's concern.
// TESTING
// - Single master 0, ARADDR=0x100, ARLEN=3, m_arready=1 -> m_arvalid 1 cycle after s_arvalid, m_arid={0,id}; 4 R beats routed to master 0; outst_cnt 0->1->0.
// - All 4 masters valid continuously -> grants in order 0,1,2,3,0; one AR every 2 cycles with m_arready tied 1.
// - m_arready held 0 for 5 cycles in ISSUE -> m_ar* stable, s_arready stays 0, then a single-cycle pulse on the handshake.
// - MAX_OUTST=2, issue 2 ARs without R -> third request not granted; an RLAST beat frees a slot -> grant on the next IDLE cycle.
// - R beat with prefix 2, s_rready[2]=0 -> m_rready=0 and the beat is held; s_rready[2]=1 -> accepted; other s_rvalid stay 0.
// - NUM_M=3, R beat with prefix 3 -> m_rready=1, err_decode pulses, no s_rvalid; areset_n low mid-ISSUE -> m_arvalid=0 immediately.

Source files
------------

// File: rtl/axi4_ar_rr_arbiter.sv
// Round-robin arbiter sharing one downstream AXI4 read port (AR + R) between NUM_M masters.
// ARID gets a master-index prefix on the way down; R beats are routed back by that prefix.
module axi4_ar_rr_arbiter #(
  parameter  int NUM_M     = 4,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 64,
  parameter  int ID_W      = 4,
  parameter  int MAX_OUTST = 8,
  localparam int SEL_W     = $clog2(NUM_M),
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [NUM_M*ID_W-1:0]   s_arid,
  input  logic [NUM_M*ADDR_W-1:0] s_araddr,
  input  logic [NUM_M*8-1:0]      s_arlen,
  input  logic [NUM_M*3-1:0]      s_arsize,
  input  logic [NUM_M*2-1:0]      s_arburst,
  input  logic [NUM_M-1:0]        s_arvalid,
  output logic [NUM_M-1:0]        s_arready,
  output logic [NUM_M*ID_W-1:0]   s_rid,
  output logic [NUM_M*DATA_W-1:0] s_rdata,
  output logic [NUM_M*2-1:0]      s_rresp,
  output logic [NUM_M-1:0]        s_rlast,
  output logic [NUM_M-1:0]        s_rvalid,
  input  logic [NUM_M-1:0]        s_rready,
  output logic [ID_W+SEL_W-1:0]   m_arid,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_W+SEL_W-1:0]   m_rid,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [CNT_W-1:0]        outst_cnt,
  output logic                    err_decode
);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  localparam logic [SEL_W:0] NUM_M_W = (SEL_W + 1)'(NUM_M);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [CNT_W-1:0]  outst_cnt_q, outst_cnt_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             can_grant;
  logic             ar_hs;
  logic             r_done;
  logic [SEL_W-1:0] sel;
  logic             sel_ok;
  logic [NUM_M-1:0] hit;

  // First requester after the previous winner, wrapping modulo NUM_M.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = (int'(last_grant_q) + 1 + k) % NUM_M;
      if (!pick_found && s_arvalid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = SEL_W'(idx);
      end
    end
  end

  assign ar_hs     = (state_q == ST_ISSUE) && m_arready;
  assign can_grant = (state_q == ST_IDLE) && pick_found && (outst_cnt_q < CNT_W'(MAX_OUTST));
  assign r_done    = m_rvalid && m_rready && m_rlast && (outst_cnt_q != '0);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    outst_cnt_d  = outst_cnt_q;
    if (can_grant) begin
      state_d   = ST_ISSUE;
      grant_d   = pick_idx;
      arid_d    = s_arid[int'(pick_idx)*ID_W +: ID_W];
      araddr_d  = s_araddr[int'(pick_idx)*ADDR_W +: ADDR_W];
      arlen_d   = s_arlen[int'(pick_idx)*8 +: 8];
      arsize_d  = s_arsize[int'(pick_idx)*3 +: 3];
      arburst_d = s_arburst[int'(pick_idx)*2 +: 2];
    end
    if (ar_hs) begin
      state_d      = ST_IDLE;
      last_grant_d = grant_q;
    end
    case ({ar_hs, r_done})
      2'b10:   outst_cnt_d = outst_cnt_q + 1'b1;
      2'b01:   outst_cnt_d = outst_cnt_q - 1'b1;
      default: outst_cnt_d = outst_cnt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SEL_W'(NUM_M - 1);
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      outst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      outst_cnt_q  <= outst_cnt_d;
    end
  end

  assign m_arvalid = (state_q == ST_ISSUE);
  assign m_arid    = {grant_q, arid_q};
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = arsize_q;
  assign m_arburst = arburst_q;
  assign outst_cnt = outst_cnt_q;

  // Prefixes beyond NUM_M-1 only exist for non-power-of-2 NUM_M; such beats are sunk.
  assign sel        = m_rid[ID_W+SEL_W-1 -: SEL_W];
  assign sel_ok     = ({1'b0, sel} < NUM_M_W);
  assign m_rready   = sel_ok ? |(s_rready & hit) : 1'b1;
  assign err_decode = m_rvalid && !sel_ok;

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_port
    assign hit[gi]                        = sel_ok && (sel == SEL_W'(gi));
    assign s_rvalid[gi]                   = m_rvalid && hit[gi];
    assign s_rlast[gi]                    = m_rlast && hit[gi];
    assign s_rid[gi*ID_W +: ID_W]         = m_rid[ID_W-1:0];
    assign s_rdata[gi*DATA_W +: DATA_W]   = m_rdata;
    assign s_rresp[gi*2 +: 2]             = m_rresp;
    assign s_arready[gi]                  = ar_hs && (grant_q == SEL_W'(gi));
  end

endmodule

// File: tb/tb_axi4_ar_rr_arbiter.sv
// Directed bench: instance a (4 masters, 8 outstanding) and instance b (3 masters, 2 outstanding).
module tb_axi4_ar_rr_arbiter;

  logic aclk = 1'b0;
  logic areset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 aclk = ~aclk;

  logic [15:0]  a_s_arid;
  logic [127:0] a_s_araddr;
  logic [31:0]  a_s_arlen;
  logic [11:0]  a_s_arsize;
  logic [7:0]   a_s_arburst;
  logic [3:0]   a_s_arvalid, a_s_arready;
  logic [15:0]  a_s_rid;
  logic [255:0] a_s_rdata;
  logic [7:0]   a_s_rresp;
  logic [3:0]   a_s_rlast, a_s_rvalid, a_s_rready;
  logic [5:0]   a_m_arid;
  logic [31:0]  a_m_araddr;
  logic [7:0]   a_m_arlen;
  logic [2:0]   a_m_arsize;
  logic [1:0]   a_m_arburst;
  logic         a_m_arvalid, a_m_arready;
  logic [5:0]   a_m_rid;
  logic [63:0]  a_m_rdata;
  logic [1:0]   a_m_rresp;
  logic         a_m_rlast, a_m_rvalid, a_m_rready;
  logic [3:0]   a_outst_cnt;
  logic         a_err_decode;

  logic [11:0]  b_s_arid;
  logic [95:0]  b_s_araddr;
  logic [23:0]  b_s_arlen;
  logic [8:0]   b_s_arsize;
  logic [5:0]   b_s_arburst;
  logic [2:0]   b_s_arvalid, b_s_arready;
  logic [11:0]  b_s_rid;
  logic [191:0] b_s_rdata;
  logic [5:0]   b_s_rresp;
  logic [2:0]   b_s_rlast, b_s_rvalid, b_s_rready;
  logic [5:0]   b_m_arid;
  logic [31:0]  b_m_araddr;
  logic [7:0]   b_m_arlen;
  logic [2:0]   b_m_arsize;
  logic [1:0]   b_m_arburst;
  logic         b_m_arvalid, b_m_arready;
  logic [5:0]   b_m_rid;
  logic [63:0]  b_m_rdata;
  logic [1:0]   b_m_rresp;
  logic         b_m_rlast, b_m_rvalid, b_m_rready;
  logic [1:0]   b_outst_cnt;
  logic         b_err_decode;

  axi4_ar_rr_arbiter #(.NUM_M(4), .ADDR_W(32), .DATA_W(64), .ID_W(4), .MAX_OUTST(8)) u_dut_a (
    .aclk(aclk), .areset_n(areset_n),
    .s_arid(a_s_arid), .s_araddr(a_s_araddr), .s_arlen(a_s_arlen), .s_arsize(a_s_arsize),
    .s_arburst(a_s_arburst), .s_arvalid(a_s_arvalid), .s_arready(a_s_arready),
    .s_rid(a_s_rid), .s_rdata(a_s_rdata), .s_rresp(a_s_rresp), .s_rlast(a_s_rlast),
    .s_rvalid(a_s_rvalid), .s_rready(a_s_rready),
    .m_arid(a_m_arid), .m_araddr(a_m_araddr), .m_arlen(a_m_arlen), .m_arsize(a_m_arsize),
    .m_arburst(a_m_arburst), .m_arvalid(a_m_arvalid), .m_arready(a_m_arready),
    .m_rid(a_m_rid), .m_rdata(a_m_rdata), .m_rresp(a_m_rresp), .m_rlast(a_m_rlast),
    .m_rvalid(a_m_rvalid), .m_rready(a_m_rready),
    .outst_cnt(a_outst_cnt), .err_decode(a_err_decode)
  );

  axi4_ar_rr_arbiter #(.NUM_M(3), .ADDR_W(32), .DATA_W(64), .ID_W(4), .MAX_OUTST(2)) u_dut_b (
    .aclk(aclk), .areset_n(areset_n),
    .s_arid(b_s_arid), .s_araddr(b_s_araddr), .s_arlen(b_s_arlen), .s_arsize(b_s_arsize),
    .s_arburst(b_s_arburst), .s_arvalid(b_s_arvalid), .s_arready(b_s_arready),
    .s_rid(b_s_rid), .s_rdata(b_s_rdata), .s_rresp(b_s_rresp), .s_rlast(b_s_rlast),
    .s_rvalid(b_s_rvalid), .s_rready(b_s_rready),
    .m_arid(b_m_arid), .m_araddr(b_m_araddr), .m_arlen(b_m_arlen), .m_arsize(b_m_arsize),
    .m_arburst(b_m_arburst), .m_arvalid(b_m_arvalid), .m_arready(b_m_arready),
    .m_rid(b_m_rid), .m_rdata(b_m_rdata), .m_rresp(b_m_rresp), .m_rlast(b_m_rlast),
    .m_rvalid(b_m_rvalid), .m_rready(b_m_rready),
    .outst_cnt(b_outst_cnt), .err_decode(b_err_decode)
  );

  // Inputs change 2 time units after a rising edge; checks follow at least 1 unit later.
  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    step();
    step();
    areset_n = 1'b1;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    step();
    n_checks++; if (a_m_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", a_m_arvalid); end
    n_checks++; if (a_s_arready !== 4'b0000) begin n_fail++; $display("FAIL reset_arready: got %b want 0000", a_s_arready); end
    n_checks++; if (a_outst_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_outst: got %0d want 0", a_outst_cnt); end
    n_checks++; if (b_err_decode !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", b_err_decode); end
    areset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    a_s_arid[3:0]   = 4'h5;
    a_s_araddr[31:0] = 32'h100;
    a_s_arlen[7:0]  = 8'd3;
    a_s_arsize[2:0] = 3'd3;
    a_s_arburst[1:0] = 2'b01;
    a_s_arvalid     = 4'b0001;
    a_m_arready     = 1'b1;
    step();
    #1;
    n_checks++; if (a_m_arvalid !== 1'b1) begin n_fail++; $display("FAIL single_arvalid: got %b want 1", a_m_arvalid); end
    n_checks++; if (a_m_arid !== 6'h05) begin n_fail++; $display("FAIL single_arid: got %h want 05", a_m_arid); end
    n_checks++; if (a_m_araddr !== 32'h100) begin n_fail++; $display("FAIL single_araddr: got %h want 100", a_m_araddr); end
    n_checks++; if (a_m_arlen !== 8'd3) begin n_fail++; $display("FAIL single_arlen: got %0d want 3", a_m_arlen); end
    n_checks++; if (a_s_arready !== 4'b0001) begin n_fail++; $display("FAIL single_arready: got %b want 0001", a_s_arready); end
    step();
    a_s_arvalid = 4'b0000;
    #1;
    n_checks++; if (a_outst_cnt !== 4'd1) begin n_fail++; $display("FAIL single_outst1: got %0d want 1", a_outst_cnt); end
    n_checks++; if (a_m_arvalid !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_drop: got %b want 0", a_m_arvalid); end
    a_s_rready = 4'b1111;
    for (int b = 0; b < 4; b++) begin
      a_m_rvalid = 1'b1;
      a_m_rid    = 6'h05;
      a_m_rdata  = 64'hA0 + 64'(b);
      a_m_rlast  = (b == 3);
      #1;
      n_checks++; if (a_s_rvalid !== 4'b0001) begin n_fail++; $display("FAIL single_rvalid beat %0d: got %b want 0001", b, a_s_rvalid); end
      n_checks++; if (a_s_rlast[0] !== (b == 3)) begin n_fail++; $display("FAIL single_rlast beat %0d: got %b", b, a_s_rlast[0]); end
      n_checks++; if (a_s_rid[3:0] !== 4'h5 || a_s_rdata[63:0] !== 64'hA0 + 64'(b)) begin n_fail++; $display("FAIL single_rpayload beat %0d: got id %h data %h", b, a_s_rid[3:0], a_s_rdata[63:0]); end
      step();
    end
    a_m_rvalid = 1'b0;
    a_m_rlast  = 1'b0;
    #1;
    n_checks++; if (a_outst_cnt !== 4'd0) begin n_fail++; $display("FAIL single_outst0: got %0d want 0", a_outst_cnt); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_s_arid[i*4 +: 4]     = 4'(8 + i);
      a_s_araddr[i*32 +: 32] = 32'h1000 * (i + 1);
    end
    a_s_arvalid = 4'b1111;
    a_m_arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      g = 2'(i % 4);
      step();
      #1;
      n_checks++; if (a_m_arvalid !== 1'b1 || a_m_arid !== {g, 4'(8 + (i % 4))}) begin n_fail++; $display("FAIL rr_grant %0d: got valid %b id %h want id %h", i, a_m_arvalid, a_m_arid, {g, 4'(8 + (i % 4))}); end
      n_checks++; if (a_s_arready !== (4'b0001 << g)) begin n_fail++; $display("FAIL rr_arready %0d: got %b want %b", i, a_s_arready, 4'b0001 << g); end
      step();
      if (i == 4) a_s_arvalid = 4'b0000;
      #1;
      n_checks++; if (a_m_arvalid !== 1'b0) begin n_fail++; $display("FAIL rr_bubble %0d: got %b want 0", i, a_m_arvalid); end
    end
    n_checks++; if (a_outst_cnt !== 4'd5) begin n_fail++; $display("FAIL rr_outst: got %0d want 5", a_outst_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    a_s_arid[8 +: 4]    = 4'h3;
    a_s_araddr[64 +: 32] = 32'h2000;
    a_s_arlen[16 +: 8]  = 8'd7;
    a_s_arvalid = 4'b0100;
    a_m_arready = 1'b0;
    step();
    a_s_arvalid = 4'b0101;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (a_m_arvalid !== 1'b1 || a_m_araddr !== 32'h2000 || a_m_arid !== 6'h23 || a_m_arlen !== 8'd7) begin n_fail++; $display("FAIL stall_hold %0d: got valid %b addr %h id %h len %0d", c, a_m_arvalid, a_m_araddr, a_m_arid, a_m_arlen); end
      n_checks++; if (a_s_arready !== 4'b0000) begin n_fail++; $display("FAIL stall_arready %0d: got %b want 0000", c, a_s_arready); end
      step();
    end
    a_m_arready = 1'b1;
    #1;
    n_checks++; if (a_s_arready !== 4'b0100) begin n_fail++; $display("FAIL stall_pulse: got %b want 0100", a_s_arready); end
    step();
    a_s_arvalid = 4'b0000;
    a_m_arready = 1'b0;
    #1;
    n_checks++; if (a_s_arready !== 4'b0000 || a_m_arvalid !== 1'b0) begin n_fail++; $display("FAIL stall_after: got arready %b arvalid %b want 0000 0", a_s_arready, a_m_arvalid); end
    n_checks++; if (a_outst_cnt !== 4'd1) begin n_fail++; $display("FAIL stall_outst: got %0d want 1", a_outst_cnt); end
  endtask

  task automatic test_r_backpressure();
    a_m_rvalid = 1'b1;
    a_m_rid    = 6'h23;
    a_m_rlast  = 1'b1;
    a_s_rready = 4'b1011;
    #1;
    n_checks++; if (a_m_rready !== 1'b0) begin n_fail++; $display("FAIL bp_rready_low: got %b want 0", a_m_rready); end
    n_checks++; if (a_s_rvalid !== 4'b0100 || a_s_rid[8 +: 4] !== 4'h3) begin n_fail++; $display("FAIL bp_route: got rvalid %b rid %h want 0100 3", a_s_rvalid, a_s_rid[8 +: 4]); end
    step();
    n_checks++; if (a_outst_cnt !== 4'd1) begin n_fail++; $display("FAIL bp_held_outst: got %0d want 1", a_outst_cnt); end
    a_s_rready = 4'b0100;
    #1;
    n_checks++; if (a_m_rready !== 1'b1) begin n_fail++; $display("FAIL bp_rready_high: got %b want 1", a_m_rready); end
    step();
    a_m_rvalid = 1'b0;
    a_m_rlast  = 1'b0;
    #1;
    n_checks++; if (a_outst_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_outst: got %0d want 0", a_outst_cnt); end
  endtask

  task automatic test_outst_cap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b_s_arid[i*4 +: 4]     = 4'(i + 1);
      b_s_araddr[i*32 +: 32] = 32'h40 * (i + 1);
    end
    b_s_arvalid = 3'b111;
    b_m_arready = 1'b1;
    step();
    #1;
    n_checks++; if (b_m_arvalid !== 1'b1 || b_m_arid !== 6'h01) begin n_fail++; $display("FAIL cap_grant0: got valid %b id %h want 1 01", b_m_arvalid, b_m_arid); end
    step();
    step();
    #1;
    n_checks++; if (b_m_arvalid !== 1'b1 || b_m_arid !== 6'h12) begin n_fail++; $display("FAIL cap_grant1: got valid %b id %h want 1 12", b_m_arvalid, b_m_arid); end
    step();
    n_checks++; if (b_outst_cnt !== 2'd2) begin n_fail++; $display("FAIL cap_outst2: got %0d want 2", b_outst_cnt); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (b_m_arvalid !== 1'b0) begin n_fail++; $display("FAIL cap_blocked %0d: got %b want 0", c, b_m_arvalid); end
    end
    b_m_rvalid = 1'b1;
    b_m_rid    = 6'h01;
    b_m_rlast  = 1'b1;
    b_s_rready = 3'b111;
    #1;
    n_checks++; if (b_s_rvalid !== 3'b001 || b_m_rready !== 1'b1) begin n_fail++; $display("FAIL cap_rbeat: got rvalid %b rready %b want 001 1", b_s_rvalid, b_m_rready); end
    step();
    b_m_rvalid = 1'b0;
    b_m_rlast  = 1'b0;
    #1;
    n_checks++; if (b_outst_cnt !== 2'd1 || b_m_arvalid !== 1'b0) begin n_fail++; $display("FAIL cap_freed: got outst %0d arvalid %b want 1 0", b_outst_cnt, b_m_arvalid); end
    b_m_arready = 1'b0;
    step();
    n_checks++; if (b_m_arvalid !== 1'b1 || b_m_arid !== 6'h23) begin n_fail++; $display("FAIL cap_grant2: got valid %b id %h want 1 23", b_m_arvalid, b_m_arid); end
  endtask

  task automatic test_decode_err();
    b_m_rvalid = 1'b1;
    b_m_rid    = 6'h31;
    b_m_rlast  = 1'b1;
    b_s_rready = 3'b000;
    #1;
    n_checks++; if (b_m_rready !== 1'b1 || b_err_decode !== 1'b1) begin n_fail++; $display("FAIL dec_sink: got rready %b err %b want 1 1", b_m_rready, b_err_decode); end
    n_checks++; if (b_s_rvalid !== 3'b000) begin n_fail++; $display("FAIL dec_rvalid: got %b want 000", b_s_rvalid); end
    step();
    n_checks++; if (b_outst_cnt !== 2'd0) begin n_fail++; $display("FAIL dec_outst: got %0d want 0", b_outst_cnt); end
    step();
    n_checks++; if (b_outst_cnt !== 2'd0) begin n_fail++; $display("FAIL dec_floor: got %0d want 0", b_outst_cnt); end
    b_m_rvalid = 1'b0;
    b_m_rlast  = 1'b0;
    #1;
    n_checks++; if (b_err_decode !== 1'b0) begin n_fail++; $display("FAIL dec_clear: got %b want 0", b_err_decode); end
  endtask

  task automatic test_reset_mid_issue();
    n_checks++; if (b_m_arvalid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got %b want 1", b_m_arvalid); end
    areset_n = 1'b0;
    #1;
    n_checks++; if (b_m_arvalid !== 1'b0 || b_s_arready !== 3'b000) begin n_fail++; $display("FAIL rst_async: got arvalid %b arready %b want 0 000", b_m_arvalid, b_s_arready); end
    b_s_arvalid = 3'b000;
    step();
    areset_n = 1'b1;
    step();
    n_checks++; if (b_m_arvalid !== 1'b0 || b_outst_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_after: got arvalid %b outst %0d want 0 0", b_m_arvalid, b_outst_cnt); end
  endtask

  initial begin
    areset_n    = 1'b0;
    a_s_arid    = '0; a_s_araddr = '0; a_s_arlen = '0; a_s_arsize = '0; a_s_arburst = '0;
    a_s_arvalid = '0; a_s_rready = '0; a_m_arready = 1'b0;
    a_m_rid     = '0; a_m_rdata  = '0; a_m_rresp = '0; a_m_rlast = 1'b0; a_m_rvalid = 1'b0;
    b_s_arid    = '0; b_s_araddr = '0; b_s_arlen = '0; b_s_arsize = '0; b_s_arburst = '0;
    b_s_arvalid = '0; b_s_rready = '0; b_m_arready = 1'b0;
    b_m_rid     = '0; b_m_rdata  = '0; b_m_rresp = '0; b_m_rlast = 1'b0; b_m_rvalid = 1'b0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_r_backpressure();
    test_outst_cap();
    test_decode_err();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
